// File: rtl/proj_sweep_sched_if.sv
// rtl/proj_sweep_sched_if.sv - requester/sweep handshake bundle for proj_sweep_sched
interface proj_sweep_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic               stall;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic [IDX_W-1:0]   index;
  logic               index_valid;
  logic               last;
  logic               done;
  logic               aborted;

  modport master (
    output req, stall,
    input  grant, grant_id, busy, index, index_valid, last, done, aborted
  );

  modport slave (
    input  req, stall,
    output grant, grant_id, busy, index, index_valid, last, done, aborted
  );
endinterface

// File: rtl/proj_sweep_sched.sv
// rtl/proj_sweep_sched.sv - shared feature-memory sweep scheduler
// PROJ_SWEEP_RR_EN selects round-robin arbitration; undefined gives fixed priority.
package proj_pkg;
  localparam int FM_BUFFER_SIZE = 8;
endpackage

module proj_sweep_sched #(
  parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = $clog2(FM_BUFFER_SIZE),
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input logic               in_clk,
  input logic               in_rst,
  proj_sweep_sched_if.slave sw
);
  typedef enum logic [1:0] {IDLE, ARB, SWEEP, DONE} state_t;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FM_BUFFER_SIZE - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [IDX_W-1:0]   index_q;
  logic               done_q, aborted_q;
  logic               index_valid, last, abort_req;

  assign index_valid = (state == SWEEP) && !sw.stall;
  assign last        = index_valid && (index_q == LAST_IDX);
  assign abort_req   = (state == SWEEP) && !sw.req[grant_id_q];

`ifdef PROJ_SWEEP_RR_EN
  logic [ID_W-1:0] rr_ptr;
  int              cand;

  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && sw.req[cand]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rr_ptr <= '0;
    end else if (state == DONE) begin
      rr_ptr <= (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
    end
  end
`else
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && sw.req[i]) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|sw.req) state_nxt = ARB;
      ARB:     state_nxt = SWEEP;
      SWEEP:   if (abort_req || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      grant_q    <= '0;
      grant_id_q <= '0;
      index_q    <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= abort_req || last;
      aborted_q <= abort_req;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_q    <= ONE_HOT0 << win_id;
            grant_id_q <= win_id;
          end
        end
        ARB:   index_q <= '0;
        // an abort freezes the index so nothing beyond the dropped entry is advertised
        SWEEP: if (index_valid && !last && !abort_req) index_q <= index_q + 1'b1;
        DONE:  grant_q <= '0;
        default: ;
      endcase
    end
  end

  assign sw.grant       = grant_q;
  assign sw.grant_id    = grant_id_q;
  assign sw.busy        = (state == ARB) || (state == SWEEP);
  assign sw.index       = index_q;
  assign sw.index_valid = index_valid;
  assign sw.last        = last;
  assign sw.done        = done_q;
  assign sw.aborted     = aborted_q;
endmodule

// File: tb/tb_proj_sweep_sched.sv
// tb/tb_proj_sweep_sched.sv - directed self-checking bench for proj_sweep_sched
module tb_proj_sweep_sched;
  localparam int FM = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   order [5];

  always #5 clk = ~clk;

  proj_sweep_sched_if #(.NUM_REQ(NR), .IDX_W(3), .ID_W(2)) sif ();

  proj_sweep_sched #(.FM_BUFFER_SIZE(FM), .NUM_REQ(NR), .IDX_W(3), .ID_W(2)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .sw     (sif)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, sif.grant, 0);
    check_eq({tag, "_grant_id"}, sif.grant_id, 0);
    check_eq({tag, "_busy"}, sif.busy, 0);
    check_eq({tag, "_index"}, sif.index, 0);
    check_eq({tag, "_index_valid"}, sif.index_valid, 0);
    check_eq({tag, "_last"}, sif.last, 0);
    check_eq({tag, "_done"}, sif.done, 0);
    check_eq({tag, "_aborted"}, sif.aborted, 0);
  endtask

  // cycle 1 = IDLE with req high; exp_cyc is the cycle in which done must be seen
  task automatic do_sweep(input logic [3:0] rq, input int exp_id, input int stall_idx,
                          input int stall_len, input int abort_idx, input int exp_cyc);
    int   exp_idx, stall_left, cyc;
    logic st, ab, fin;
    sif.req   = rq;
    sif.stall = 1'b0;
    cyc = 1;
    tick(); cyc++;
    check_eq("arb_grant", sif.grant, 1 << exp_id);
    check_eq("arb_grant_id", sif.grant_id, exp_id);
    check_eq("arb_busy", sif.busy, 1);
    check_eq("arb_index_valid", sif.index_valid, 0);
    tick(); cyc++;
    exp_idx    = 0;
    stall_left = stall_len;
    fin        = 1'b0;
    ab         = 1'b0;
    while (!fin && cyc < 64) begin
      st = (exp_idx == stall_idx) && (stall_left > 0);
      sif.stall = st;
      if (st) stall_left--;
      ab = !st && (exp_idx == abort_idx);
      if (ab) sif.req = '0;
      #1;
      check_eq("sweep_index", sif.index, exp_idx);
      check_eq("sweep_index_valid", sif.index_valid, int'(!st));
      check_eq("sweep_last", sif.last, int'(!st && exp_idx == FM - 1));
      check_eq("sweep_done", sif.done, 0);
      if (!st) begin
        if (ab || exp_idx == FM - 1) fin = 1'b1;
        else exp_idx++;
      end
      tick(); cyc++;
    end
    sif.stall = 1'b0;
    check_eq("done_pulse", sif.done, 1);
    check_eq("done_aborted", sif.aborted, int'(ab));
    check_eq("done_cycle", cyc, exp_cyc);
    check_eq("done_grant_held", sif.grant, 1 << exp_id);
    check_eq("done_index_valid", sif.index_valid, 0);
    sif.req = '0;
    tick();
    check_eq("post_done", sif.done, 0);
    check_eq("post_busy", sif.busy, 0);
    check_eq("post_grant", sif.grant, 0);
  endtask

  initial begin
    int busy_seen;
    rst       = 1'b1;
    sif.req   = '0;
    sif.stall = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_seen |= int'(sif.busy);
    end
    check_eq("idle_busy", busy_seen, 0);

    do_sweep(4'b0100, 2, -1, 0, -1, 11);
    do_sweep(4'b0100, 2, 3, 5, -1, 16);
    do_sweep(4'b0001, 0, -1, 0, 5, 9);
    tick();
    check_eq("abort_idle_busy", sif.busy, 0);

    sif.req = 4'b1000;
    tick(); tick();
    for (int i = 0; i < 4; i++) tick();
    check_eq("midrst_index", sif.index, 4);
    check_eq("midrst_grant_id", sif.grant_id, 3);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst     = 1'b0;
    sif.req = '0;
    tick();
    check_eq("midrst_no_done", sif.done, 0);

`ifdef PROJ_SWEEP_RR_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++) do_sweep(4'b1111, order[k], -1, 0, -1, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
